// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types for the forwarding / hazard controller: operand mux select
// codes, controller state encoding and the shadow pipeline-stage record.
package fwd_hazard_ctrl_pkg;

    // ALU operand source select; 2'b11 is never produced.
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // Controller state: normal flow, or EX held by a multi-cycle mult/div.
    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MDU_BUSY = 1'b1
    } state_t;

    // Register 0 is hard-wired to zero and must never be a forwarding source.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Shadow copy of the hazard-relevant fields of one pipeline register.
    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic       regwrite;
        logic       memread;
        logic       mdu;
    } stage_t;

    localparam stage_t STAGE_EMPTY = '0;

    // True when a stage will write a real (non-zero) register equal to src.
    function automatic logic dst_hits(input logic       valid,
                                      input logic       regwrite,
                                      input logic [4:0] dst,
                                      input logic [4:0] src);
        return valid && regwrite && (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_fwd_cmp.sv
// Combinational forwarding select for one ALU operand: compares the EX
// source register against the MEM and WB destinations, MEM winning.
module fwd_cmp
    import fwd_hazard_ctrl_pkg::*;
(
    input  logic       ex_valid,
    input  logic [4:0] src,
    input  logic       mem_valid,
    input  logic       mem_regwrite,
    input  logic [4:0] mem_dst,
    input  logic       wb_valid,
    input  logic       wb_regwrite,
    input  logic [4:0] wb_dst,
    output fwd_sel_t   sel
);

    // Youngest producer (EX/MEM) has priority over the older MEM/WB value.
    always_comb begin
        sel = FWD_REG;
        if (ex_valid) begin
            if (dst_hits(mem_valid, mem_regwrite, mem_dst, src)) begin
                sel = FWD_MEM;
            end else if (dst_hits(wb_valid, wb_regwrite, wb_dst, src)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller. Keeps shadow copies of the EX, MEM and
// WB pipeline registers, derives ALU operand forwarding selects, detects
// load-use hazards and sequences multi-cycle mult/div occupancy of EX.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MDU_LAT = 4
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [4:0] id_dst,
    input  logic       id_regwrite,
    input  logic       id_memread,
    input  logic       id_mdu,
    output logic [1:0] forward_a,
    output logic [1:0] forward_b,
    output logic       stall,
    output logic       bubble_ex,
    output logic       hold_ex
);

    localparam logic [3:0] CNT_LOAD = 4'(MDU_LAT - 1);

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    stage_t     ex_reg, ex_next;
    stage_t     mem_reg, mem_next;
    stage_t     wb_reg, wb_next;
    stage_t     id_stage;

    logic       busy_hold;
    logic       load_use;
    logic       mdu_enter;

    logic [4:0] src_sel [2];
    fwd_sel_t   sel     [2];

    // Hazard detection: the MDU hold owns EX; load-use only matters in RUN.
    always_comb begin
        busy_hold = (state_reg == ST_MDU_BUSY) && (cnt_reg != 4'd0);
        load_use  = (state_reg == ST_RUN) && ex_reg.valid && ex_reg.memread &&
                    (ex_reg.dst != REG_ZERO) && id_valid &&
                    ((ex_reg.dst == id_rs) || (ex_reg.dst == id_rt));
        // The counter is armed as the mult/div enters EX, so its first EX
        // cycle is already counted and total occupancy is MDU_LAT cycles.
        mdu_enter = !busy_hold && !load_use && id_valid && id_mdu &&
                    (MDU_LAT > 1);
    end

    // Next shadow-stage contents: hold, bubble or normal advance.
    always_comb begin
        id_stage.valid    = id_valid;
        id_stage.rs       = id_rs;
        id_stage.rt       = id_rt;
        id_stage.dst      = id_dst;
        id_stage.regwrite = id_regwrite;
        id_stage.memread  = id_memread;
        id_stage.mdu      = id_mdu;

        ex_next  = ex_reg;
        mem_next = ex_reg;
        wb_next  = mem_reg;

        if (busy_hold) begin
            // EX frozen under the mult/div; MEM sees an empty slot.
            ex_next  = ex_reg;
            mem_next = STAGE_EMPTY;
        end else if (load_use) begin
            // Consumer stays in ID; EX gets a one-cycle bubble.
            ex_next.valid = 1'b0;
        end else if (id_valid) begin
            ex_next = id_stage;
        end else begin
            ex_next.valid = 1'b0;
        end
    end

    // FSM next state and occupancy counter.
    always_comb begin
        state_next = ST_RUN;
        cnt_next   = 4'd0;
        if (mdu_enter) begin
            state_next = ST_MDU_BUSY;
            cnt_next   = CNT_LOAD;
        end else if (busy_hold) begin
            state_next = ST_MDU_BUSY;
            cnt_next   = cnt_reg - 4'd1;
        end
    end

    // State registers with synchronous reset back to an empty pipeline in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_RUN;
            cnt_reg   <= 4'd0;
            ex_reg    <= STAGE_EMPTY;
            mem_reg   <= STAGE_EMPTY;
            wb_reg    <= STAGE_EMPTY;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ex_reg    <= ex_next;
            mem_reg   <= mem_next;
            wb_reg    <= wb_next;
        end
    end

    assign src_sel[0] = ex_reg.rs;
    assign src_sel[1] = ex_reg.rt;

    // One comparator per ALU operand (0 = A/rs, 1 = B/rt).
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_cmp u_cmp (
                .ex_valid     (ex_reg.valid),
                .src          (src_sel[gi]),
                .mem_valid    (mem_reg.valid),
                .mem_regwrite (mem_reg.regwrite),
                .mem_dst      (mem_reg.dst),
                .wb_valid     (wb_reg.valid),
                .wb_regwrite  (wb_reg.regwrite),
                .wb_dst       (wb_reg.dst),
                .sel          (sel[gi])
            );
        end
    endgenerate

    // Outputs are quiet while reset is held, whatever the state registers show.
    always_comb begin
        forward_a = rst ? FWD_REG : sel[0];
        forward_b = rst ? FWD_REG : sel[1];
        stall     = !rst && (load_use || busy_hold);
        bubble_ex = !rst && load_use;
        hold_ex   = !rst && busy_hold;
    end

    // WB only matters for its destination; the remaining fields ride along.
    logic wb_fields_unused;
    assign wb_fields_unused = ^{wb_reg.rs, wb_reg.rt, wb_reg.memread, wb_reg.mdu};

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: forwarding priority, register-0
// suppression, load-use stall, mult/div occupancy (MDU_LAT=4 and 1), reset.
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_dst;
    logic       id_regwrite, id_memread, id_mdu;

    logic [1:0] forward_a, forward_b;
    logic       stall, bubble_ex, hold_ex;
    logic [1:0] forward_a1, forward_b1;
    logic       stall1, bubble_ex1, hold_ex1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.MDU_LAT(4)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs),
        .id_rt(id_rt), .id_dst(id_dst), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_mdu(id_mdu),
        .forward_a(forward_a), .forward_b(forward_b), .stall(stall),
        .bubble_ex(bubble_ex), .hold_ex(hold_ex)
    );

    fwd_hazard_ctrl #(.MDU_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs),
        .id_rt(id_rt), .id_dst(id_dst), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_mdu(id_mdu),
        .forward_a(forward_a1), .forward_b(forward_b1), .stall(stall1),
        .bubble_ex(bubble_ex1), .hold_ex(hold_ex1)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
            $display("check %-16s obs=%0d exp=%0d ok", tag, obs, exp);
        end else begin
            $display("FAIL %-16s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] dst, input logic rw, input logic mr,
                          input logic mdu);
        id_valid = v; id_rs = rs; id_rt = rt; id_dst = dst;
        id_regwrite = rw; id_memread = mr; id_mdu = mdu;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                         input logic rw, input logic mr, input logic mdu);
        set_id(1'b1, rs, rt, dst, rw, mr, mdu);
        step();
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic flush();
        nop();
        step(); step(); step();
    endtask

    initial begin
        rst = 1'b1;
        nop();
        step();
        // Outputs quiet during reset
        chk("rst_fwd_a", forward_a, 0);
        chk("rst_fwd_b", forward_b, 0);
        chk("rst_stall", stall, 0);
        chk("rst_bubble", bubble_ex, 0);
        chk("rst_hold", hold_ex, 0);
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_state", int'(dut.state_reg), 0);

        // r3 in MEM, consumer rs=3 in EX
        issue(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
        issue(5'd3, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
        nop();
        chk("mem_fwd_a", forward_a, 2);
        chk("mem_rt0_b", forward_b, 0);
        flush();

        // r3 in WB only, consumer rs=rt=3
        issue(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
        nop(); step();
        issue(5'd3, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0);
        nop();
        chk("wb_fwd_a", forward_a, 1);
        chk("wb_fwd_b", forward_b, 1);
        flush();

        // r3 written by both MEM and WB: MEM wins
        issue(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
        issue(5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
        issue(5'd3, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0);
        nop();
        chk("both_fwd_a", forward_a, 2);
        chk("both_fwd_b", forward_b, 0);
        flush();

        // operand B from MEM
        issue(5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0);
        issue(5'd1, 5'd4, 5'd11, 1'b1, 1'b0, 1'b0);
        nop();
        chk("memb_fwd_a", forward_a, 0);
        chk("memb_fwd_b", forward_b, 2);
        flush();

        // register 0 never forwards
        issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        issue(5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0);
        nop();
        chk("r0_fwd_a", forward_a, 0);
        chk("r0_fwd_b", forward_b, 0);
        flush();

        // invalid EX (stale rs=3) with r3 in MEM: no forward
        issue(5'd3, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0);
        nop(); step();
        chk("exinv_fwd_a", forward_a, 0);
        flush();

        // load-use: lw r5 in EX, ID rt=5
        issue(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
        set_id(1'b1, 5'd1, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
        chk("lu_stall", stall, 1);
        chk("lu_bubble", bubble_ex, 1);
        chk("lu_hold", hold_ex, 0);
        step();
        chk("lu_stall_2nd", stall, 0);
        chk("lu_bubble_2nd", bubble_ex, 0);
        step();
        nop();
        chk("lu_fwd_b", forward_b, 1);
        chk("lu_fwd_a", forward_a, 0);
        flush();

        // load into r0 and load with invalid ID: no stall
        issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        set_id(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
        chk("lu_r0_stall", stall, 0);
        flush();
        issue(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
        set_id(1'b0, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
        chk("lu_idinv_stall", stall, 0);
        flush();

        // mult/div: add r2 then mult rs=2
        issue(5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0);
        issue(5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        set_id(1'b1, 5'd1, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0);
        chk("mdu1_stall", stall, 1);
        chk("mdu1_hold", hold_ex, 1);
        chk("mdu1_bubble", bubble_ex, 0);
        chk("mdu1_fwd_a", forward_a, 2);
        chk("lat1_stall", stall1, 0);
        chk("lat1_hold", hold_ex1, 0);
        step();
        chk("mdu2_stall", stall, 1);
        chk("mdu2_hold", hold_ex, 1);
        chk("mdu2_mem_v", dut.mem_reg.valid, 0);
        chk("mdu2_fwd_a", forward_a, 1);
        chk("lat1_stall2", stall1, 0);
        step();
        chk("mdu3_stall", stall, 1);
        chk("mdu3_hold", hold_ex, 1);
        chk("mdu3_mem_v", dut.mem_reg.valid, 0);
        step();
        chk("mdu4_stall", stall, 0);
        chk("mdu4_hold", hold_ex, 0);
        chk("mdu4_mem_v", dut.mem_reg.valid, 0);
        nop();
        step();
        chk("mdu_out_mem_v", dut.mem_reg.valid, 1);
        chk("mdu_out_stall", stall, 0);
        chk("mdu_out_state", int'(dut.state_reg), 0);
        flush();

        // reset during second MDU_BUSY cycle
        issue(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        nop();
        step();
        chk("rmdu_pre_stall", stall, 1);
        rst = 1'b1;
        #1;
        chk("rmdu_dur_stall", stall, 0);
        chk("rmdu_dur_hold", hold_ex, 0);
        step();
        rst = 1'b0;
        #1;
        chk("rmdu_stall", stall, 0);
        chk("rmdu_hold", hold_ex, 0);
        chk("rmdu_bubble", bubble_ex, 0);
        chk("rmdu_fwd_a", forward_a, 0);
        chk("rmdu_fwd_b", forward_b, 0);
        chk("rmdu_state", int'(dut.state_reg), 0);
        step();
        chk("rmdu_stall_nx", stall, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 Parameter MDU_LAT, default 4, number of EX cycles a mult/div occupies (legal 1..15).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 id_valid  in  1  ID stage holds a real instruction.
REQ-005 id_rs / id_rt  in  5 each  ID-stage source register numbers.
REQ-006 id_dst  in  5  ID-stage destination register number.
REQ-007 id_regwrite / id_memread / id_mdu  in  1 each  ID instruction writes reg / is load / is mult-div.
REQ-008 forward_a / forward_b  out  2 each  ALU operand mux selects: 00 reg file, 10 EX/MEM, 01 MEM/WB; 11 never driven.
REQ-009 stall  out  1  hold PC and IF/ID register.
REQ-010 bubble_ex  out  1  load zeroed controls into ID/EX.
REQ-011 hold_ex  out  1  freeze ID/EX contents (MDU busy).

Function
REQ-012 Block SHALL keep shadow stages EX, MEM, WB, each {valid, rs, rt, dst, regwrite, memread, mdu}, mirroring pipeline registers.
REQ-013 Normal advance: ID->EX, EX->MEM, MEM->WB each cycle; ID fields captured only when id_valid=1, else EX valid=0.
REQ-014 forward_a SHALL be 10 when MEM.valid, MEM.regwrite, MEM.dst!=0, MEM.dst==EX.rs; else 01 when same on WB; else 00. forward_b identical using EX.rt.
REQ-015 EX/MEM match SHALL take priority over MEM/WB; register 0 SHALL never forward; forward outputs 00 when EX.valid=0.
REQ-016 Forward outputs combinational from registered shadow state only (no dependency on id_* inputs).
REQ-017 FSM states RUN, MDU_BUSY.
REQ-018 RUN, load-use: EX.valid, EX.memread, EX.dst!=0, id_valid, EX.dst in {id_rs,id_rt} -> stall=1, bubble_ex=1 same cycle; next edge EX.valid=0, MEM/WB advance, ID re-evaluated next cycle (exactly one stall cycle per hazard).
REQ-019 RUN, EX.valid and EX.mdu -> next state MDU_BUSY, counter loaded MDU_LAT-1; if MDU_LAT=1 stay RUN, no stall.
REQ-020 MDU_BUSY: stall=1, hold_ex=1, bubble_ex=0; EX shadow frozen; MEM receives bubble (valid=0); WB advances; counter decrements.
REQ-021 MDU_BUSY with counter==0 -> RUN; that cycle stall=0, hold_ex=0, EX advances normally.
REQ-022 Load-use check SHALL be suppressed in MDU_BUSY (stall already asserted); re-evaluated on return to RUN.
REQ-023 MDU total EX occupancy SHALL equal MDU_LAT cycles; stall asserted MDU_LAT-1 cycles.
REQ-024 Forwarding during MDU_BUSY SHALL still reflect frozen EX vs current MEM/WB.
REQ-025 stall, bubble_ex, hold_ex SHALL never all be 0 while a load-use hazard exists in RUN; hold_ex and bubble_ex never both 1.

Reset
REQ-026 rst SHALL clear all shadow valid bits, set state RUN, counter 0.
REQ-027 During/after reset: forward_a=forward_b=00, stall=0, bubble_ex=0, hold_ex=0.
REQ-028 rst mid-MDU or mid-stall SHALL abort immediately to RUN at next edge, no residual stall.

Structure
REQ-029 Shared package SHALL hold fwd_sel_t enum (FWD_REG=00, FWD_WB=01, FWD_MEM=10), state enum, shadow-stage struct, REG_ZERO constant.
REQ-030 One sub-module fwd_cmp (combinational source/destination match producing one fwd_sel_t), instantiated twice (A, B).

Verification
REQ-031 add r3 in MEM, EX.rs=3 -> forward_a=10; same with r3 in WB only -> 01; both MEM and WB write r3 -> 10.
REQ-032 MEM.dst=0 regwrite=1, EX.rs=0 -> forward_a=00.
REQ-033 lw r5 in EX, ID rt=5 -> stall=1, bubble_ex=1 one cycle; next cycle forward_b=01 when consumer reaches EX.
REQ-034 MDU_LAT=4, mult enters EX -> stall=1, hold_ex=1 for exactly 3 cycles, MEM valid=0 for those 3, then RUN.
REQ-035 rst asserted during 2nd MDU_BUSY cycle -> next cycle all outputs 0/00, state RUN.
REQ-036 MDU_LAT=1, mult enters EX -> no stall asserted.
